ring_buffer_word_reader: RTL and testbench

- Consumer for the ring buffer's read port.
- Issues single-cycle read requests and checks the acknowledge.
- Packs successive WordSize-bit entries little-endian into one wide word and presents it on a valid/ready output.
- Sits between the ring buffer and downstream word-wide logic, e.g. a memory write path or CPU port.

---
 rtl/ring_buffer_pkg.sv | 49 ++++
 rtl/ring_buffer_word_reader.sv | 167 ++++++++++++++++
 tb/tb_ring_buffer_word_reader.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ring_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ring_buffer_pkg
//  Description : Shared definitions for the ring buffer word reader.
//                - reader state enumeration (fixed encoding, visible on debug)
//                - default entry width and packing factor
//                - bit offsets / widths of the fields in the debug word
//                - helper that assembles the debug word
//  Revision    : 1.0 - initial release
// ============================================================================
package ring_buffer_pkg;

    // Encoding is externally visible through the debug port and must not
    // be reordered.
    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_BACKOFF = 2'd2,
        ST_PRESENT = 2'd3
    } reader_state_e;

    localparam int DEFAULT_WORD_SIZE      = 8;
    localparam int DEFAULT_BYTES_PER_WORD = 4;
    localparam int DEFAULT_RETRY_DELAY    = 4;

    // debug = {state[3:0], byteCount[3:0], missCount[23:0]}
    localparam int DBG_W         = 32;
    localparam int DBG_MISS_LSB  = 0;
    localparam int DBG_MISS_W    = 24;
    localparam int DBG_BYTE_LSB  = 24;
    localparam int DBG_BYTE_W    = 4;
    localparam int DBG_STATE_LSB = 28;
    localparam int DBG_STATE_W   = 4;

    function automatic logic [DBG_W-1:0] pack_debug(
        input logic [DBG_STATE_W-1:0] state_f,
        input logic [DBG_BYTE_W-1:0]  byte_f,
        input logic [DBG_MISS_W-1:0]  miss_f
    );
        logic [DBG_W-1:0] word;
        word = '0;
        word[DBG_STATE_LSB +: DBG_STATE_W] = state_f;
        word[DBG_BYTE_LSB  +: DBG_BYTE_W]  = byte_f;
        word[DBG_MISS_LSB  +: DBG_MISS_W]  = miss_f;
        return word;
    endfunction

endpackage : ring_buffer_pkg
`default_nettype wire

// File: rtl/ring_buffer_word_reader.sv
`default_nettype none
// ============================================================================
//  Module      : ring_buffer_word_reader
//  Description : Pulls entries out of a ring buffer read port one at a time,
//                packs BytesPerWord of them little-endian into one wide word
//                and offers that word on a valid/ready interface.
//                Refused reads back off for RetryDelay idle cycles.
//
//  Ports       :
//    clk            in   1          clock
//    reset          in   1          asynchronous active-low reset
//    dataReadEnable out  1          single-cycle read request to the buffer
//    dataReadAck    in   1          buffer read success (valid cycle after req)
//    dataRead       in   WordSize   entry returned by the buffer
//    wordOut        out  OutWidth   assembled word (qualified by wordValid)
//    wordValid      out  1          wordOut holds a complete word
//    wordReady      in   1          downstream accepts wordOut
//    debug          out  32         {state, byteCount, missCount}
//
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_buffer_word_reader
    import ring_buffer_pkg::*;
#(
    parameter int WordSize     = DEFAULT_WORD_SIZE,
    parameter int BytesPerWord = DEFAULT_BYTES_PER_WORD,
    parameter int RetryDelay   = DEFAULT_RETRY_DELAY
) (
    input  logic                             clk,
    input  logic                             reset,
    output logic                             dataReadEnable,
    input  logic                             dataReadAck,
    input  logic [WordSize-1:0]              dataRead,
    output logic [WordSize*BytesPerWord-1:0] wordOut,
    output logic                             wordValid,
    input  logic                             wordReady,
    output logic [DBG_W-1:0]                 debug
);

    localparam int OutWidth     = WordSize * BytesPerWord;
    localparam int BYTE_CNT_W   = $clog2(BytesPerWord);
    localparam int BACKOFF_W    = $clog2(RetryDelay + 1);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE     = BYTE_CNT_W'(BytesPerWord - 1);
    localparam logic [BACKOFF_W-1:0]  BACKOFF_LOAD  = BACKOFF_W'(RetryDelay);
    localparam logic [BACKOFF_W-1:0]  BACKOFF_LAST  = BACKOFF_W'(1);

    // ------------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------------
    if (BytesPerWord < 2) begin : g_bad_bytes_per_word
        $error("BytesPerWord must be at least 2");
    end
    if (RetryDelay < 1) begin : g_bad_retry_delay
        $error("RetryDelay must be at least 1");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    reader_state_e             state_q,      state_d;
    logic [BYTE_CNT_W-1:0]     byte_count_q, byte_count_d;
    logic [DBG_MISS_W-1:0]     miss_count_q, miss_count_d;
    logic [BACKOFF_W-1:0]      backoff_q,    backoff_d;
    logic [OutWidth-1:0]       word_out_q,   word_out_d;
    logic                      word_valid_q, word_valid_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_REQ;
            byte_count_q <= '0;
            miss_count_q <= '0;
            backoff_q    <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_count_q <= byte_count_d;
            miss_count_q <= miss_count_d;
            backoff_q    <= backoff_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        byte_count_d = byte_count_q;
        miss_count_d = miss_count_q;
        backoff_d    = backoff_q;
        word_out_d   = word_out_q;
        word_valid_d = word_valid_q;

        unique case (state_q)
            // The request pulse lives for exactly this one cycle; holding it
            // longer would pop further entries from the buffer.
            ST_REQ: begin
                state_d = ST_WAIT;
            end

            // Ack/data were updated by the buffer at the edge that ended the
            // request cycle, so they are only trustworthy right here.
            ST_WAIT: begin
                if (dataReadAck) begin
                    for (int b = 0; b < BytesPerWord; b++) begin
                        if (byte_count_q == BYTE_CNT_W'(b)) begin
                            word_out_d[b*WordSize +: WordSize] = dataRead;
                        end
                    end
                    if (byte_count_q == LAST_BYTE) begin
                        byte_count_d = '0;
                        word_valid_d = 1'b1;
                        state_d      = ST_PRESENT;
                    end else begin
                        byte_count_d = byte_count_q + BYTE_CNT_W'(1);
                        state_d      = ST_REQ;
                    end
                end else begin
                    if (miss_count_q != '1) begin
                        miss_count_d = miss_count_q + DBG_MISS_W'(1);
                    end
                    backoff_d = BACKOFF_LOAD;
                    state_d   = ST_BACKOFF;
                end
            end

            ST_BACKOFF: begin
                if (backoff_q <= BACKOFF_LAST) begin
                    state_d = ST_REQ;
                end else begin
                    backoff_d = backoff_q - BACKOFF_W'(1);
                end
            end

            // No prefetch: the next entry is requested only after the word
            // has been handed off.
            ST_PRESENT: begin
                if (word_valid_q && wordReady) begin
                    word_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The reset state is REQ, yet the request must stay low while reset is
    // held; qualifying with the reset pin lets the first pulse appear in the
    // very first cycle after release without an extra idle cycle.
    assign dataReadEnable = (state_q == ST_REQ) && reset;
    assign wordOut        = word_out_q;
    assign wordValid      = word_valid_q;
    assign debug          = pack_debug(DBG_STATE_W'(state_q),
                                       DBG_BYTE_W'(byte_count_q),
                                       miss_count_q);

endmodule : ring_buffer_word_reader
`default_nettype wire

// File: tb/tb_ring_buffer_word_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_buffer_word_reader
//  Description : Self-checking bench for ring_buffer_word_reader with a
//                behavioural ring buffer model and a word scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_buffer_word_reader;

    localparam int WS  = 8;
    localparam int BPW = 4;
    localparam int RD  = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        dataReadEnable;
    logic        dataReadAck;
    logic [7:0]  dataRead;
    logic [31:0] wordOut;
    logic        wordValid;
    logic        wordReady = 1'b0;
    logic [31:0] debug;

    ring_buffer_word_reader #(
        .WordSize     (WS),
        .BytesPerWord (BPW),
        .RetryDelay   (RD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dataReadEnable (dataReadEnable),
        .dataReadAck    (dataReadAck),
        .dataRead       (dataRead),
        .wordOut        (wordOut),
        .wordValid      (wordValid),
        .wordReady      (wordReady),
        .debug          (debug)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Ring buffer model
    // ------------------------------------------------------------------------
    int         cyc = 0;
    logic [7:0] buf_q[$];
    int         refuse_cnt = 0;
    int         coll_idx[$];
    logic [7:0] coll_val[$];
    bit         rand_mode = 1'b0;
    int         req_log[$];
    logic [7:0] popped[$];
    int         model_misses = 0;

    int checks = 0;
    int errors = 0;

    initial begin : buffer_model
        logic       req;
        bit         collide;
        bit         refuse;
        logic [7:0] wv;
        int         r;
        // Sticky ack starts high: the reader must ignore it while in reset.
        dataReadAck = 1'b1;
        dataRead    = 8'h00;
        forever begin
            @(posedge clk);
            req = dataReadEnable;
            cyc++;
            #1;
            if (req) begin
                collide = 1'b0;
                refuse  = 1'b0;
                wv      = 8'h00;
                if (coll_idx.size() > 0 && coll_idx[0] == req_log.size()) begin
                    collide = 1'b1;
                    wv      = coll_val[0];
                    coll_idx.delete(0);
                    coll_val.delete(0);
                end else if (rand_mode) begin
                    r = $urandom_range(0, 9);
                    if (r == 0) begin
                        collide = 1'b1;
                        wv      = 8'($urandom);
                    end else if (r == 1) begin
                        refuse = 1'b1;
                    end
                end
                if (!collide && refuse_cnt > 0) begin
                    refuse = 1'b1;
                    refuse_cnt--;
                end
                req_log.push_back(cyc - 1);
                if (collide) begin
                    buf_q.push_back(wv);
                    dataReadAck = 1'b0;
                    model_misses++;
                end else if (refuse || buf_q.size() == 0) begin
                    dataReadAck = 1'b0;
                    model_misses++;
                end else begin
                    dataReadAck = 1'b1;
                    dataRead    = buf_q.pop_front();
                    popped.push_back(dataRead);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_word(input int limit, output bit ok);
        int n = 0;
        while (!wordValid && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = wordValid;
        if (!ok) check("word_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [7:0]  e0, e1, e2, e3;
        int          misses;
        int          ready_delay;
        int          exp_latency;
        logic [31:0] exp_word;
        int          exp_miss;
    } vec_t;

    vec_t vecs[4];

    // Entered during a REQ cycle (request visible, not yet sampled).
    task automatic run_vec(input int idx, input vec_t v);
        int  base;
        int  first;
        bit  ok;
        base = req_log.size();
        first = cyc;
        buf_q.push_back(v.e0);
        buf_q.push_back(v.e1);
        buf_q.push_back(v.e2);
        buf_q.push_back(v.e3);
        refuse_cnt = v.misses;
        wordReady  = (v.ready_delay == 0);
        @(negedge clk);
        wait_word(300, ok);
        if (ok) begin
            check($sformatf("v%0d_latency", idx), cyc - first, v.exp_latency);
            check($sformatf("v%0d_word", idx), wordOut, v.exp_word);
            check($sformatf("v%0d_debug", idx), debug, {4'd3, 4'd0, 24'(v.exp_miss)});
            check($sformatf("v%0d_req_count", idx), req_log.size() - base, 4 + v.misses);
            check($sformatf("v%0d_req_span", idx),
                  req_log[req_log.size()-1] - req_log[base], v.exp_latency - 2);
            for (int d = 0; d < v.ready_delay; d++) begin
                @(negedge clk);
                check($sformatf("v%0d_hold_ctl", idx), {wordValid, dataReadEnable}, 2'b10);
                check($sformatf("v%0d_hold_word", idx), wordOut, v.exp_word);
            end
            wordReady = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d_release", idx), {wordValid, dataReadEnable}, 2'b01);
        end
    endtask

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin : main
        bit          ok;
        int          base;
        int          words;
        bit          in_word;
        bit          prev_en;
        int          prev_phase;
        logic [31:0] exp_cur;

        vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 0, 0,  8, 32'h44332211, 0};
        vecs[1] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 3, 0, 26, 32'hA3A2A1A0, 3};
        vecs[2] = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 0, 10, 8, 32'hF00FC35A, 3};
        vecs[3] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 1, 2, 14, 32'hEFBEADDE, 4};

        // Reset held with ack high
        repeat (3) @(negedge clk);
        check("rst_enable", dataReadEnable, 0);
        check("rst_valid", wordValid, 0);
        check("rst_debug", debug, 0);
        check("rst_wordout", wordOut, 0);
        reset = 1'b1;
        #1;
        check("post_rst_enable", dataReadEnable, 1);

        // Table-driven single-word transactions
        for (int i = 0; i < 4; i++) begin
            run_vec(i, vecs[i]);
        end

        // Concurrent writes collide with two requests
        base = req_log.size();
        for (int i = 0; i < 6; i++) buf_q.push_back(8'(i));
        coll_idx.push_back(base + 2); coll_val.push_back(8'h06);
        coll_idx.push_back(base + 7); coll_val.push_back(8'h07);
        wordReady = 1'b1;
        @(negedge clk);
        wait_word(300, ok);
        if (ok) check("coll_word0", wordOut, 32'h03020100);
        @(negedge clk);
        wait_word(300, ok);
        if (ok) begin
            check("coll_word1", wordOut, 32'h07060504);
            check("coll_miss", debug[23:0], 6);
        end
        @(negedge clk);
        check("coll_req_count", req_log.size() - base, 10);

        // Reset in WAIT after two entries accepted
        for (int i = 0; i < 8; i++) buf_q.push_back(8'h30 + 8'(i));
        repeat (5) @(negedge clk);
        check("mid_state", debug[31:24], {4'd1, 4'd2});
        reset = 1'b0;
        #1;
        check("mid_rst_ctl", {wordValid, dataReadEnable}, 2'b00);
        check("mid_rst_debug", debug, 0);
        check("mid_rst_wordout", wordOut, 0);
        model_misses = 0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rel_enable", dataReadEnable, 1);
        wait_word(300, ok);
        if (ok) begin
            check("mid_word", wordOut, 32'h36353433);
            check("mid_miss", debug[23:0], 0);
        end
        @(negedge clk);

        // Randomised traffic against the word scoreboard
        popped.delete();
        rand_mode  = 1'b1;
        words      = 0;
        in_word    = 1'b0;
        prev_en    = 1'b0;
        prev_phase = 0;
        exp_cur    = '0;
        for (int c = 0; c < 1500; c++) begin
            if (buf_q.size() < 6 && $urandom_range(0, 3) != 0) buf_q.push_back(8'($urandom));
            if (prev_en) check("rand_en_pulse", dataReadEnable, 0);
            if (prev_phase == 1) check("rand_hold", wordValid, 1);
            if (prev_phase == 2) check("rand_accept", {wordValid, dataReadEnable}, 2'b01);
            if (wordValid) begin
                if (!in_word) begin
                    check("rand_popped", popped.size(), 4);
                    if (popped.size() >= 4) begin
                        exp_cur = {popped[3], popped[2], popped[1], popped[0]};
                        for (int k = 0; k < 4; k++) popped.delete(0);
                    end
                    words++;
                    in_word = 1'b1;
                end
                check("rand_word", wordOut, exp_cur);
            end
            wordReady  = ($urandom_range(0, 2) != 0);
            prev_phase = !wordValid ? 0 : (wordReady ? 2 : 1);
            if (wordValid && wordReady) in_word = 1'b0;
            prev_en = dataReadEnable;
            @(negedge clk);
        end
        rand_mode = 1'b0;
        wordReady = 1'b1;
        for (int i = 0; i < 40; i++) buf_q.push_back(8'(i));
        repeat (30) @(negedge clk);
        check("rand_words", words > 10, 1);
        check("rand_miss_count", debug[23:0], 24'(model_misses));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ring_buffer_word_reader
`default_nettype wire
